// File: rtl/imem_arbiter.sv
// Two-way arbiter for the instruction-memory read port (fetch vs debug); IMEM_ARB_RR_EN swaps starvation-counter priority for round-robin.
// Grant is combinational with the request; rdata/rvalid are registered one cycle after grant; losers simply hold req until granted.
module imem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic win_f;
    logic win_d;
    logic debug_turn;

`ifdef IMEM_ARB_RR_EN
    logic last_f;

    assign debug_turn = last_f;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_f <= 1'b0;
        end else if (win_f) begin
            last_f <= 1'b1;
        end else if (win_d) begin
            last_f <= 1'b0;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign debug_turn = (starve_cnt >= LIMIT);

    // Counts only cycles where debug actually lost to fetch; a dropped d_req leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (win_d) begin
            starve_cnt <= 4'd0;
        end else if (d_req && win_f && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        win_f = 1'b0;
        win_d = 1'b0;
        if (rst_n) begin
            if (f_req && d_req) begin
                win_d = debug_turn;
                win_f = !debug_turn;
            end else begin
                win_f = f_req;
                win_d = d_req;
            end
        end
    end

    assign f_gnt    = win_f;
    assign d_gnt    = win_d;
    assign mem_addr = win_f ? f_addr : (win_d ? d_addr : '0);

    // Separate data registers per requester so the loser's rdata keeps its last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= win_f;
            d_rvalid <= win_d;
            if (win_f) begin
                f_rdata <= mem_rdata;
            end
            if (win_d) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_imem_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req, d_req;
    logic [AW-1:0] f_addr, d_addr, mem_addr;
    logic          f_gnt, d_gnt, f_rvalid, d_rvalid;
    logic [DW-1:0] f_rdata, d_rdata, mem_rdata;

    logic [DW-1:0] mem [0:1023];

    int checks = 0;
    int failures = 0;

    // Observed values: grant side sampled mid-cycle, response side just after the following edge.
    logic          o_fg, o_dg, o_frv, o_drv;
    logic [AW-1:0] o_ma;
    logic [DW-1:0] o_frd, o_drd;

    // Reference model state.
    int            m_starve;
    bit            m_last_f;
    bit            e_fg, e_dg, m_frv, m_drv;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] m_frd, m_drd;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    function automatic void model_arb();
        e_fg = 1'b0;
        e_dg = 1'b0;
        if (rst_n) begin
            if (f_req && d_req) begin
`ifdef IMEM_ARB_RR_EN
                e_dg = m_last_f;
`else
                e_dg = (m_starve == STARVE_LIMIT);
`endif
                e_fg = !e_dg;
            end else begin
                e_fg = f_req;
                e_dg = d_req;
            end
        end
        e_ma = e_fg ? f_addr : (e_dg ? d_addr : 12'h000);
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            m_starve = 0; m_last_f = 1'b0;
            m_frv = 1'b0; m_drv = 1'b0; m_frd = '0; m_drd = '0;
        end else begin
            m_frv = e_fg;
            m_drv = e_dg;
            if (e_fg) m_frd = mem[f_addr >> 2];
            if (e_dg) m_drd = mem[d_addr >> 2];
            if (e_dg) m_starve = 0;
            else if (d_req && e_fg && m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
            if (e_fg) m_last_f = 1'b1;
            else if (e_dg) m_last_f = 1'b0;
        end
    endfunction

    task automatic tick(input bit r, input bit fr, input logic [AW-1:0] fa,
                        input bit dr, input logic [AW-1:0] da);
        rst_n = r; f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        model_arb();
        @(negedge clk);
        o_fg = f_gnt; o_dg = d_gnt; o_ma = mem_addr;
        @(posedge clk);
        model_edge();
        #1;
        o_frv = f_rvalid; o_drv = d_rvalid; o_frd = f_rdata; o_drd = d_rdata;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 12'h010, 1'b1, 12'h004);
            checks += 7;
            if (o_fg !== 1'b0) begin failures++; $display("FAIL reset_f_gnt cyc=%0d got=%b exp=0", i, o_fg); end
            if (o_dg !== 1'b0) begin failures++; $display("FAIL reset_d_gnt cyc=%0d got=%b exp=0", i, o_dg); end
            if (o_ma !== 12'h000) begin failures++; $display("FAIL reset_mem_addr cyc=%0d got=%h exp=000", i, o_ma); end
            if (o_frv !== 1'b0) begin failures++; $display("FAIL reset_f_rvalid cyc=%0d got=%b exp=0", i, o_frv); end
            if (o_drv !== 1'b0) begin failures++; $display("FAIL reset_d_rvalid cyc=%0d got=%b exp=0", i, o_drv); end
            if (o_frd !== 32'h0) begin failures++; $display("FAIL reset_f_rdata cyc=%0d got=%h exp=0", i, o_frd); end
            if (o_drd !== 32'h0) begin failures++; $display("FAIL reset_d_rdata cyc=%0d got=%h exp=0", i, o_drd); end
        end
    endtask

    task automatic test_single_fetch();
        tick(1'b1, 1'b1, 12'h010, 1'b0, 12'h000);
        checks += 6;
        if (o_fg !== 1'b1) begin failures++; $display("FAIL single_f_gnt got=%b exp=1", o_fg); end
        if (o_dg !== 1'b0) begin failures++; $display("FAIL single_d_gnt got=%b exp=0", o_dg); end
        if (o_ma !== 12'h010) begin failures++; $display("FAIL single_mem_addr got=%h exp=010", o_ma); end
        if (o_frv !== 1'b1) begin failures++; $display("FAIL single_f_rvalid got=%b exp=1", o_frv); end
        if (o_frd !== 32'hDEADBEEF) begin failures++; $display("FAIL single_f_rdata got=%h exp=deadbeef", o_frd); end
        if (o_drv !== 1'b0) begin failures++; $display("FAIL single_d_rvalid got=%b exp=0", o_drv); end
        tick(1'b1, 1'b0, 12'h000, 1'b0, 12'h000);
        checks += 1;
        if (o_frv !== 1'b0) begin failures++; $display("FAIL single_f_rvalid_one_cycle got=%b exp=0", o_frv); end
    endtask

    // Default build: debug wins every (LIMIT+1)th contended cycle. Round-robin build: fetch, debug, fetch, ...
    task automatic test_contention();
        bit exp_d;
        tick(1'b0, 1'b0, 12'h000, 1'b0, 12'h000);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 12'h000, 1'b1, 12'h004);
`ifdef IMEM_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = (i % (STARVE_LIMIT + 1)) == STARVE_LIMIT;
`endif
            checks += 5;
            if (o_dg !== exp_d) begin failures++; $display("FAIL contend_d_gnt cyc=%0d got=%b exp=%b", i, o_dg, exp_d); end
            if (o_fg !== !exp_d) begin failures++; $display("FAIL contend_f_gnt cyc=%0d got=%b exp=%b", i, o_fg, !exp_d); end
            if (o_drv !== exp_d) begin failures++; $display("FAIL contend_d_rvalid cyc=%0d got=%b exp=%b", i, o_drv, exp_d); end
            if (o_frv !== !exp_d) begin failures++; $display("FAIL contend_f_rvalid cyc=%0d got=%b exp=%b", i, o_frv, !exp_d); end
            if (exp_d ? (o_drd !== mem[1]) : (o_frd !== mem[0])) begin
                failures++;
                $display("FAIL contend_rdata cyc=%0d got_f=%h got_d=%h exp=%h", i, o_frd, o_drd, exp_d ? mem[1] : mem[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0, 12'h000, 1'b1, 12'h020);
        checks += 5;
        if (o_dg !== 1'b1) begin failures++; $display("FAIL b2b_d_gnt got=%b exp=1", o_dg); end
        if (o_ma !== 12'h020) begin failures++; $display("FAIL b2b_addr0 got=%h exp=020", o_ma); end
        if (o_drv !== 1'b1) begin failures++; $display("FAIL b2b_d_rvalid got=%b exp=1", o_drv); end
        if (o_frv !== 1'b0) begin failures++; $display("FAIL b2b_f_rvalid0 got=%b exp=0", o_frv); end
        if (o_drd !== mem[8]) begin failures++; $display("FAIL b2b_d_rdata got=%h exp=%h", o_drd, mem[8]); end
        tick(1'b1, 1'b1, 12'h024, 1'b0, 12'h000);
        checks += 6;
        if (o_fg !== 1'b1) begin failures++; $display("FAIL b2b_f_gnt got=%b exp=1", o_fg); end
        if (o_ma !== 12'h024) begin failures++; $display("FAIL b2b_addr1 got=%h exp=024", o_ma); end
        if (o_frv !== 1'b1) begin failures++; $display("FAIL b2b_f_rvalid got=%b exp=1", o_frv); end
        if (o_drv !== 1'b0) begin failures++; $display("FAIL b2b_d_rvalid1 got=%b exp=0", o_drv); end
        if (o_frd !== mem[9]) begin failures++; $display("FAIL b2b_f_rdata got=%h exp=%h", o_frd, mem[9]); end
        if (o_drd !== mem[8]) begin failures++; $display("FAIL b2b_d_rdata_hold got=%h exp=%h", o_drd, mem[8]); end
    endtask

    task automatic test_reset_mid();
        bit exp_d;
        tick(1'b1, 1'b1, 12'h000, 1'b1, 12'h004);
        tick(1'b1, 1'b1, 12'h000, 1'b1, 12'h004);
        tick(1'b0, 1'b1, 12'h010, 1'b0, 12'h000);
        checks += 3;
        if (o_fg !== 1'b0) begin failures++; $display("FAIL rstmid_f_gnt got=%b exp=0", o_fg); end
        if (o_frv !== 1'b0) begin failures++; $display("FAIL rstmid_f_rvalid got=%b exp=0", o_frv); end
        if (o_frd !== 32'h0) begin failures++; $display("FAIL rstmid_f_rdata got=%h exp=0", o_frd); end
        // A cleared counter means the full LIMIT fetch wins before debug gets through.
        for (int i = 0; i <= STARVE_LIMIT; i++) begin
            tick(1'b1, 1'b1, 12'h000, 1'b1, 12'h004);
`ifdef IMEM_ARB_RR_EN
            exp_d = (i % 2) == 1;
`else
            exp_d = (i == STARVE_LIMIT);
`endif
            checks += 1;
            if (o_dg !== exp_d) begin failures++; $display("FAIL rstmid_d_gnt cyc=%0d got=%b exp=%b", i, o_dg, exp_d); end
        end
    endtask

    task automatic test_random();
        bit            fr = 1'b0, dr = 1'b0, r;
        logic [AW-1:0] fa = '0, da = '0;
        for (int i = 0; i < 400; i++) begin
            // Keep the address stable while a request is pending; occasionally withdraw it.
            if (!fr || o_fg) begin fr = ($urandom_range(0, 3) != 0); fa = 12'($urandom); end
            else if ($urandom_range(0, 9) == 0) fr = 1'b0;
            if (!dr || o_dg) begin dr = ($urandom_range(0, 2) != 0); da = 12'($urandom); end
            else if ($urandom_range(0, 9) == 0) dr = 1'b0;
            r = ($urandom_range(0, 39) != 0);
            o_fg = 1'b0; o_dg = 1'b0;
            tick(r, fr, fa, dr, da);
            checks += 7;
            if (o_fg !== e_fg) begin failures++; $display("FAIL rand_f_gnt cyc=%0d got=%b exp=%b", i, o_fg, e_fg); end
            if (o_dg !== e_dg) begin failures++; $display("FAIL rand_d_gnt cyc=%0d got=%b exp=%b", i, o_dg, e_dg); end
            if (o_ma !== e_ma) begin failures++; $display("FAIL rand_mem_addr cyc=%0d got=%h exp=%h", i, o_ma, e_ma); end
            if (o_frv !== m_frv) begin failures++; $display("FAIL rand_f_rvalid cyc=%0d got=%b exp=%b", i, o_frv, m_frv); end
            if (o_drv !== m_drv) begin failures++; $display("FAIL rand_d_rvalid cyc=%0d got=%b exp=%b", i, o_drv, m_drv); end
            if (o_frd !== m_frd) begin failures++; $display("FAIL rand_f_rdata cyc=%0d got=%h exp=%h", i, o_frd, m_frd); end
            if (o_drd !== m_drd) begin failures++; $display("FAIL rand_d_rdata cyc=%0d got=%h exp=%h", i, o_drd, m_drd); end
            if (!r) begin fr = 1'b0; dr = 1'b0; end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[12'h010 >> 2] = 32'hDEADBEEF;
        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        m_starve = 0; m_last_f = 1'b0; m_frv = 1'b0; m_drv = 1'b0; m_frd = '0; m_drd = '0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

- Shares the single combinational read port of the instruction memory between two requesters: the core fetch path and a debug/trace reader.
- Grants at most one requester per cycle and drives the memory address from the winner.
- Registers the returned word and returns it to the winner one cycle later.
- Uses fixed fetch priority plus a starvation counter, so debug accesses complete without stalling fetch indefinitely.

## Interface

Parameters
- ADDR_WIDTH, 12, byte-address width; matches the instruction memory.
- DATA_WIDTH, 32, instruction word width.
- STARVE_LIMIT, 4, consecutive lost debug cycles before debug wins; legal range 1..15.

Ports
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- f_req  input  1  fetch request; held with f_addr stable until f_gnt.
- f_addr  input  ADDR_WIDTH  fetch byte address.
- f_gnt  output  1  fetch granted this cycle (combinational).
- f_rvalid  output  1  fetch response valid, one cycle after grant.
- f_rdata  output  DATA_WIDTH  fetch response word.
- d_req  input  1  debug request; held with d_addr stable until d_gnt.
- d_addr  input  ADDR_WIDTH  debug byte address.
- d_gnt  output  1  debug granted this cycle (combinational).
- d_rvalid  output  1  debug response valid, one cycle after grant.
- d_rdata  output  DATA_WIDTH  debug response word.
- mem_addr  output  ADDR_WIDTH  address to the instruction memory.
- mem_rdata  input  DATA_WIDTH  combinational read data from the instruction memory.

## Operation

- **Arbitration** is evaluated each cycle on f_req, d_req and starve_cnt (4-bit):
  - Only one request: that requester wins.
  - Both requesting, starve_cnt < STARVE_LIMIT: fetch wins.
  - Both requesting, starve_cnt == STARVE_LIMIT: debug wins.
- **Grant:** the winner's gnt is asserted and mem_addr = winner's address.
- **Idle:** with no request, mem_addr = 0 and both gnt are 0.
- **Response capture:** on a granted cycle, mem_rdata is captured into a response register tagged with the winner.
  - The next cycle asserts the matching rvalid for exactly one cycle.
  - The non-winning rdata holds its previous value.
- **starve_cnt:**
  - Increments, saturating at STARVE_LIMIT, when d_req=1 and fetch wins.
  - Clears to 0 on any d_gnt.
  - Holds otherwise, including while d_req=0.
- **Back-to-back grants** are allowed every cycle; no bubble is required between requesters or between same-requester accesses.
- **Addresses** are passed unmodified; word alignment is the memory's concern (it ignores the low log2(DATA_WIDTH/8) bits).

## Timing

- Grant latency is 0 cycles: gnt is combinational from req in the same cycle.
- Data latency is 1 cycle: rvalid/rdata are valid in the cycle after gnt, registered.
- Reset values (rst_n=0 at a rising edge):
  - f_rvalid=0, d_rvalid=0, f_rdata=0, d_rdata=0, starve_cnt=0, response tag cleared.
  - While rst_n=0: f_gnt=0, d_gnt=0, mem_addr=0 regardless of requests.
- Reset mid-operation: a grant in the cycle where rst_n is sampled low is dropped; no rvalid follows.
- Simultaneous request arrival with starve_cnt=0: fetch wins; starve_cnt becomes 1.
- Saturation: starve_cnt never exceeds STARVE_LIMIT. STARVE_LIMIT=1 alternates fetch/debug under continuous contention.
- A requester deasserting req without a grant is legal; no state beyond starve_cnt is affected. Clearing starve_cnt on d_req drop is not done.

## Configuration

- IMEM_ARB_RR_EN defined: the starvation counter is removed and contention is resolved round-robin.
  - A 1-bit last-winner register (reset: debug) is used; under contention the requester that did not win last time wins.
  - The last-winner register updates on every grant.
- IMEM_ARB_RR_EN undefined: fixed fetch priority with starve_cnt and STARVE_LIMIT as above.
- STARVE_LIMIT is ignored when IMEM_ARB_RR_EN is defined.
- Ports and latency are identical in both builds.

## Test plan

- **Reset:** hold rst_n=0 for 3 cycles with f_req=d_req=1 -> f_gnt=d_gnt=0, mem_addr=0, both rvalid=0, both rdata=0.
- **Single fetch:** f_req=1, f_addr=0x010, memory word 0xDEADBEEF at 0x010 -> f_gnt=1 in cycle N; f_rvalid=1 with f_rdata=0xDEADBEEF in N+1; d_rvalid stays 0.
- **Starvation, default build, STARVE_LIMIT=4:** f_req and d_req held high, f_addr=0x000, d_addr=0x004 -> f_gnt in cycles 0–3, d_gnt in cycle 4, f_gnt in cycles 5–8, d_gnt in cycle 9; d_rvalid in cycles 5 and 10.
- **Back-to-back alternation:** debug-only request at 0x020, then fetch-only request at 0x024 on consecutive cycles -> d_rvalid then f_rvalid in consecutive cycles with the correct words; starve_cnt=0 throughout.
- **Reset mid-access:** fetch granted at cycle N with rst_n sampled low at the end of cycle N -> f_rvalid=0 in N+1; starve_cnt=0.
- **Round-robin, IMEM_ARB_RR_EN defined:** both requesting continuously from reset -> grants fetch, debug, fetch, debug...; each rvalid follows its grant by one cycle.
